// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and requester IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select between core and DMA requests.
// MEM_ARBITER_RR_EN selects round-robin on contention; otherwise core always wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic core_req,
    input  logic dma_req,
`ifdef MEM_ARBITER_RR_EN
    input  logic last_owner,
`endif
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = core_req | dma_req;
        grant = OWN_CORE;
        if (core_req && dma_req) begin
`ifdef MEM_ARBITER_RR_EN
            // Contention goes to whoever did not hold the previous grant.
            grant = (last_owner == OWN_CORE) ? OWN_DMA : OWN_CORE;
`else
            grant = OWN_CORE;
`endif
        end else if (dma_req) begin
            grant = OWN_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between the core and a DMA port on one shared memory.
// Optional round-robin contention policy under MEM_ARBITER_RR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_done,
    output logic [DW-1:0] core_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_done,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          owner
);

    state_t          r_state;
    logic            r_mem_en;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_core_done;
    logic            r_dma_done;
    logic [DW-1:0]   r_core_rdata;
    logic [DW-1:0]   r_dma_rdata;
    logic            r_busy;
    logic            r_owner;
    logic            w_grant;
    logic            w_valid;
`ifdef MEM_ARBITER_RR_EN
    logic            r_last_owner;
`endif

    arb_pick u_arb_pick (
        .core_req   (core_req),
        .dma_req    (dma_req),
`ifdef MEM_ARBITER_RR_EN
        .last_owner (r_last_owner),
`endif
        .grant      (w_grant),
        .valid      (w_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_core_done  <= 1'b0;
            r_dma_done   <= 1'b0;
            r_core_rdata <= '0;
            r_dma_rdata  <= '0;
            r_busy       <= 1'b0;
            r_owner      <= OWN_CORE;
`ifdef MEM_ARBITER_RR_EN
            r_last_owner <= OWN_CORE;
`endif
        end else begin
            r_core_done <= 1'b0;
            r_dma_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner  <= w_grant;
`ifdef MEM_ARBITER_RR_EN
                        r_last_owner <= w_grant;
`endif
                        r_mem_en <= 1'b1;
                        r_busy   <= 1'b1;
                        if (w_grant == OWN_DMA) begin
                            r_mem_we    <= dma_we;
                            r_mem_addr  <= dma_addr;
                            r_mem_wdata <= dma_wdata;
                        end else begin
                            r_mem_we    <= core_we;
                            r_mem_addr  <= core_addr;
                            r_mem_wdata <= core_wdata;
                        end
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Command is held from the grant; requester inputs are ignored here.
                    if (mem_ready) begin
                        if (!r_mem_we) begin
                            if (r_owner == OWN_DMA) begin
                                r_dma_rdata <= mem_rdata;
                            end else begin
                                r_core_rdata <= mem_rdata;
                            end
                        end
                        if (r_owner == OWN_DMA) begin
                            r_dma_done <= 1'b1;
                        end else begin
                            r_core_done <= 1'b1;
                        end
                        r_mem_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign core_done  = r_core_done;
    assign dma_done   = r_dma_done;
    assign core_rdata = r_core_rdata;
    assign dma_rdata  = r_dma_rdata;
    assign busy       = r_busy;
    assign owner      = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, dma_req, dma_we;
    logic [AW-1:0] core_addr, dma_addr, mem_addr;
    logic [DW-1:0] core_wdata, dma_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] core_rdata, dma_rdata;
    logic          core_done, dma_done, mem_en, mem_we, mem_ready, busy, owner;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: last grant holder and each requester's read-data register.
    bit            m_last;
    logic [DW-1:0] m_core_rdata;
    logic [DW-1:0] m_dma_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_done  (core_done),
        .core_rdata (core_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_done   (dma_done),
        .dma_rdata  (dma_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .owner      (owner)
    );

    // Who should win given the current requests: 0 = core, 1 = DMA.
    function automatic bit pick(input bit c, input bit d, input bit last);
`ifdef MEM_ARBITER_RR_EN
        if (c && d) return !last;
`endif
        return c ? 1'b0 : 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle with requests already driven; ends in the following IDLE cycle.
    task automatic run_txn(input int lat, input logic [DW-1:0] rd, input bit scramble,
                           input bit keep_core, input bit keep_dma);
        bit            eo;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        eo  = pick(core_req, dma_req, m_last);
        ewe = eo ? dma_we : core_we;
        ea  = eo ? dma_addr : core_addr;
        ewd = eo ? dma_wdata : core_wdata;
        m_last = eo;
        step();
        n_checks++;
        if ({mem_en, busy, owner, mem_we, core_done, dma_done} !== {1'b1, 1'b1, eo, ewe, 2'b00}) begin
            n_errors++;
            $display("FAIL grant_ctrl: en/busy/owner/we/cdone/ddone got %b want %b",
                     {mem_en, busy, owner, mem_we, core_done, dma_done}, {1'b1, 1'b1, eo, ewe, 2'b00});
        end
        n_checks++;
        if (mem_addr !== ea || mem_wdata !== ewd) begin
            n_errors++;
            $display("FAIL grant_cmd: addr %h wdata %h want addr %h wdata %h", mem_addr, mem_wdata, ea, ewd);
        end
        for (int i = 0; i < lat; i++) begin
            if (scramble) begin
                core_addr  = $urandom;
                dma_addr   = $urandom;
                core_wdata = $urandom;
                dma_wdata  = $urandom;
                core_we    = 1'($urandom_range(0, 1));
                dma_we     = 1'($urandom_range(0, 1));
            end
            step();
            n_checks++;
            if ({mem_en, busy, mem_we, core_done, dma_done} !== {1'b1, 1'b1, ewe, 2'b00}
                || mem_addr !== ea || mem_wdata !== ewd) begin
                n_errors++;
                $display("FAIL hold: en/busy/we/cd/dd %b addr %h wdata %h want %b addr %h wdata %h",
                         {mem_en, busy, mem_we, core_done, dma_done}, mem_addr, mem_wdata,
                         {1'b1, 1'b1, ewe, 2'b00}, ea, ewd);
            end
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        step();
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (!ewe) begin
            if (eo) m_dma_rdata = rd;
            else    m_core_rdata = rd;
        end
        n_checks++;
        if ({core_done, dma_done, mem_en, busy, owner} !== {~eo, eo, 2'b00, eo}) begin
            n_errors++;
            $display("FAIL done_pulse: cd/dd/en/busy/owner got %b want %b",
                     {core_done, dma_done, mem_en, busy, owner}, {~eo, eo, 2'b00, eo});
        end
        n_checks++;
        if (core_rdata !== m_core_rdata || dma_rdata !== m_dma_rdata) begin
            n_errors++;
            $display("FAIL rdata: core %h dma %h want core %h dma %h",
                     core_rdata, dma_rdata, m_core_rdata, m_dma_rdata);
        end
        core_req = core_req & keep_core;
        dma_req  = dma_req & keep_dma;
        step();
        n_checks++;
        if ({core_done, dma_done, mem_en, busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL after_done: cd/dd/en/busy got %b want 0000", {core_done, dma_done, mem_en, busy});
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #13;
        n_checks++;
        if ({mem_en, mem_we, core_done, dma_done, busy, owner} !== 6'b0 || mem_addr !== '0
            || mem_wdata !== '0 || core_rdata !== '0 || dma_rdata !== '0) begin
            n_errors++;
            $display("FAIL reset_values: ctrl %b addr %h wdata %h crd %h drd %h want all zero",
                     {mem_en, mem_we, core_done, dma_done, busy, owner}, mem_addr, mem_wdata,
                     core_rdata, dma_rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        m_last = 1'b0;
        m_core_rdata = '0;
        m_dma_rdata = '0;
        step();
        n_checks++;
        if ({mem_en, busy, core_done, dma_done} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_idle: en/busy/cd/dd got %b want 0000", {mem_en, busy, core_done, dma_done});
        end
    endtask

    task automatic test_core_read();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; core_wdata = 32'h0;
        run_txn(2, 32'hE3A01005, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (core_rdata !== 32'hE3A01005) begin
            n_errors++;
            $display("FAIL core_read_data: got %h want e3a01005", core_rdata);
        end
    endtask

    task automatic test_dma_write();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hDEADBEEF;
        run_txn(0, 32'h12345678, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dma_rdata !== 32'h0 || core_rdata !== 32'hE3A01005) begin
            n_errors++;
            $display("FAIL dma_write_rdata: dma %h core %h want dma 0 core e3a01005", dma_rdata, core_rdata);
        end
    endtask

    task automatic test_simultaneous();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
        dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 32'h200;
        for (int i = 0; i < 4; i++) begin
            run_txn($urandom_range(0, 2), $urandom, 1'b0, 1'b1, 1'b1);
            core_addr = core_addr + 4;
            dma_addr  = dma_addr + 4;
        end
        run_txn(1, $urandom, 1'b0, 1'b0, 1'b1);
        run_txn(1, $urandom, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_input_change();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h20;
        run_txn(5, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_access();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h30; core_wdata = 32'h0;
        dma_req = 1'b0;
        step();
        step();
        n_checks++;
        if ({mem_en, busy} !== 2'b11) begin
            n_errors++;
            $display("FAIL pre_abort: en/busy got %b want 11", {mem_en, busy});
        end
        reset = 1'b0;
        #1;
        m_last = 1'b0;
        m_core_rdata = '0;
        m_dma_rdata = '0;
        n_checks++;
        if ({mem_en, busy, core_done, dma_done} !== 4'b0000 || core_rdata !== '0) begin
            n_errors++;
            $display("FAIL abort: en/busy/cd/dd %b crd %h want 0000 crd 0",
                     {mem_en, busy, core_done, dma_done}, core_rdata);
        end
        #2;
        reset = 1'b1;
        run_txn(1, 32'h0BADC0DE, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stray_ready();
        core_req = 1'b0; dma_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            mem_rdata = $urandom;
            step();
            n_checks++;
            if ({mem_en, busy, core_done, dma_done} !== 4'b0000 || core_rdata !== m_core_rdata
                || dma_rdata !== m_dma_rdata) begin
                n_errors++;
                $display("FAIL stray_ready: en/busy/cd/dd %b crd %h drd %h", {mem_en, busy, core_done, dma_done},
                         core_rdata, dma_rdata);
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            core_req   = 1'($urandom_range(0, 1));
            dma_req    = 1'($urandom_range(0, 1));
            if (!core_req && !dma_req) dma_req = 1'b1;
            core_we    = 1'($urandom_range(0, 1));
            dma_we     = 1'($urandom_range(0, 1));
            core_addr  = $urandom;
            dma_addr   = $urandom;
            core_wdata = $urandom;
            dma_wdata  = $urandom;
            run_txn($urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        core_req = 1'b0;
        dma_req  = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        m_last = 1'b0; m_core_rdata = '0; m_dma_rdata = '0;
        test_reset();
        test_core_read();
        test_dma_write();
        test_stray_ready();
        test_simultaneous();
        test_input_change();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle core between two requesters: the core (fetch/load/store issued by the main FSM) and an auxiliary DMA/loader port.
- Sits between the datapath's address mux (AdrSrc) and the memory.
- The core's main FSM stalls while its request is pending.
- One access is in flight at a time. Memory latency is variable and is signalled by mem_ready.

Parameters:
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
core_req  in  1  core access request, level, held until core_done
core_we  in  1  core write enable (1=store)
core_addr  in  AW  core byte address
core_wdata  in  DW  core store data
core_done  out  1  one-cycle pulse: core access complete
core_rdata  out  DW  core load data, valid with core_done, held after
dma_req  in  1  DMA access request, level, held until dma_done
dma_we  in  1  DMA write enable
dma_addr  in  AW  DMA byte address
dma_wdata  in  DW  DMA write data
dma_done  out  1  one-cycle pulse: DMA access complete
dma_rdata  out  DW  DMA read data, valid with dma_done, held after
mem_en  out  1  memory access strobe, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completes current access this cycle
busy  out  1  1 while an access is in flight (state ACCESS)
owner  out  1  0=core, 1=DMA; grant holder of the current/last access

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE; mem_en, mem_we, core_done, dma_done, busy, owner = 0; mem_addr, mem_wdata, core_rdata, dma_rdata = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is high: choose the winner; register winner's we/addr/wdata into mem_we/mem_addr/mem_wdata; set owner; mem_en<=1, busy<=1; next state ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_en/mem_we/mem_addr/mem_wdata are held constant.
  - On mem_ready=1: if !mem_we, latch mem_rdata into the owner's rdata register; mem_en<=0, busy<=0; next state DONE.
  - Otherwise stay in ACCESS (no timeout).
- DONE:
  - Owner's done=1 for exactly this cycle; the other requester's done stays 0.
  - Next state IDLE. No arbitration happens in DONE, so the requester can drop req.
- Latency: request seen in IDLE at cycle 0 → mem_en=1 from cycle 1 → mem_ready at cycle k≥1 → done pulse at cycle k+1. Minimum 2 cycles; throughput one access per (latency+2) cycles.
- Fixed priority (default): core beats DMA on simultaneous requests, so DMA can starve under continuous core requests.
- Write completion leaves both rdata registers unchanged.
- Boundary conditions:
  - Requester drops req during ACCESS: the access still completes and the done pulse is still issued.
  - Request inputs change during ACCESS: ignored, because command outputs are registered.
  - mem_ready while IDLE or DONE: ignored.
  - Reset asserted mid-access: mem_en and done drop immediately; on release the FSM is in IDLE; the aborted access is not retried.
  - Same requester re-requests right after its done: it arbitrates normally in the following IDLE cycle.
- Core integration: the main FSM holds its fetch/memory states while core_req & !core_done. IRWrite/result capture use core_done.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined: round-robin priority. A last_owner register (reset 0) is updated at each grant. On simultaneous requests the requester that did not win the previous grant wins, so continuous requesters alternate.
- Undefined: fixed core-first priority as above; no last_owner register.
- A lone request is granted identically in both builds.

Decomposition:
- Shared package mem_arb_pkg:
  - FSM state encoding: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10.
  - Owner IDs: OWN_CORE=1'b0, OWN_DMA=1'b1.
- One sub-module is natural: arb_pick, a combinational winner select. Inputs: core_req, dma_req, last_owner. Output: grant id plus valid. It holds the fixed or RR policy under the macro.

Test Plan:
- Core read: core_req=1, we=0, addr=0x10; mem_ready 2 cycles after mem_en with rdata=0xE3A01005 → mem_addr=0x10, core_done pulse at cycle 4, core_rdata=0xE3A01005, dma_done=0.
- DMA write: dma_req=1, we=1, addr=0x40, wdata=0xDEADBEEF, mem_ready immediate → mem_we=1, mem_wdata=0xDEADBEEF, dma_done at cycle 2, dma_rdata unchanged.
- Simultaneous requests, fixed priority: both req at cycle 0 → owner=0 first; DMA granted only after core_done and core_req deasserted. With MEM_ARBITER_RR_EN and both held high for 4 accesses → owners 0,1,0,1.
- Mid-access input change: core_addr changes 0x20→0x24 during ACCESS, mem_ready delayed 5 cycles → mem_addr stays 0x20 throughout.
- Reset mid-access: reset low during ACCESS → mem_en=0 and busy=0 immediately; after release, state IDLE; a held core_req is re-granted 1 cycle later.
- Stray mem_ready: mem_ready=1 while IDLE with no requests → no done pulses, mem_en stays 0.
